// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing generator.
// Produces a pixel-rate strobe, horizontal/vertical counters whose origin is the
// start of the sync pulse, active-low sync pulses and the video-on window.
// Optional feature macro: VGA_FRAME_CNT_EN adds a 16-bit frames-completed counter.
module vga_sync_gen #(
    parameter int CLK_DIV = 4,
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HSP     = 96,
    parameter int VSP     = 2,
    parameter int HBP     = 144,
    parameter int HFP     = 784,
    parameter int VBP     = 31,
    parameter int VFP     = 511
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        pix_en,
    output logic [9:0]  hc,
    output logic [9:0]  vc,
    output logic        hsync,
    output logic        vsync,
    output logic        vidon,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    // A 1-bit divider is kept even when CLK_DIV=1 so the counter never has zero width.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
    localparam logic [9:0] V_LAST = 10'(VLINES - 1);
    localparam logic [9:0] HSP_C  = 10'(HSP);
    localparam logic [9:0] VSP_C  = 10'(VSP);
    localparam logic [9:0] HBP_C  = 10'(HBP);
    localparam logic [9:0] HFP_C  = 10'(HFP);
    localparam logic [9:0] VBP_C  = 10'(VBP);
    localparam logic [9:0] VFP_C  = 10'(VFP);

    logic [DIV_W-1:0] div_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic [9:0]       hc_next;
    logic [9:0]       vc_next;

    // Pixel-rate divider: pix_en is registered, high the clk after div_cnt reaches its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Next counter position; vc only moves when hc wraps, and wraps only together with hc.
    always_comb begin
        h_wrap  = (hc == H_LAST);
        v_wrap  = (vc == V_LAST);
        hc_next = h_wrap ? 10'd0 : hc + 10'd1;
        vc_next = vc;
        if (h_wrap) begin
            vc_next = v_wrap ? 10'd0 : vc + 10'd1;
        end
    end

    // Counters and decoded timing, all derived from the next position so they line up with hc/vc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc          <= '0;
            vc          <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            vidon       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                hc          <= hc_next;
                vc          <= vc_next;
                hsync       <= (hc_next >= HSP_C);
                vsync       <= (vc_next >= VSP_C);
                vidon       <= (hc_next >= HBP_C) && (hc_next < HFP_C) &&
                               (vc_next >= VBP_C) && (vc_next < VFP_C);
                line_start  <= h_wrap;
                frame_start <= h_wrap && v_wrap;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frames-completed counter, stepping on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen.
// A default-parameter instance covers start-up, line timing and mid-line reset;
// a shrunken instance (20x12 pixels, CLK_DIV=2) covers the visible window and frame wrap.
// With VGA_FRAME_CNT_EN defined a CLK_DIV=1 instance also exercises frame_cnt.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic d_pix_en, d_hsync, d_vsync, d_vidon, d_line_start, d_frame_start;
    logic [9:0] d_hc, d_vc;
    logic s_pix_en, s_hsync, s_vsync, s_vidon, s_line_start, s_frame_start;
    logic [9:0] s_hc, s_vc;
`ifdef VGA_FRAME_CNT_EN
    logic c_pix_en, c_hsync, c_vsync, c_vidon, c_line_start, c_frame_start;
    logic [9:0] c_hc, c_vc;
    logic [15:0] d_frame_cnt, s_frame_cnt, c_frame_cnt;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Free-running system clock.
    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk(clk), .rst_n(rst_n), .pix_en(d_pix_en), .hc(d_hc), .vc(d_vc),
        .hsync(d_hsync), .vsync(d_vsync), .vidon(d_vidon),
        .line_start(d_line_start), .frame_start(d_frame_start)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(d_frame_cnt)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(2), .HPIXELS(20), .VLINES(12), .HSP(3), .VSP(2),
        .HBP(5), .HFP(17), .VBP(3), .VFP(10)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_en(s_pix_en), .hc(s_hc), .vc(s_vc),
        .hsync(s_hsync), .vsync(s_vsync), .vidon(s_vidon),
        .line_start(s_line_start), .frame_start(s_frame_start)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(s_frame_cnt)
`endif
    );

`ifdef VGA_FRAME_CNT_EN
    vga_sync_gen #(
        .CLK_DIV(1), .HPIXELS(20), .VLINES(12), .HSP(3), .VSP(2),
        .HBP(5), .HFP(17), .VBP(3), .VFP(10)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .pix_en(c_pix_en), .hc(c_hc), .vc(c_vc),
        .hsync(c_hsync), .vsync(c_vsync), .vidon(c_vidon),
        .line_start(c_line_start), .frame_start(c_frame_start),
        .frame_cnt(c_frame_cnt)
    );
`endif

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Drive reset level at a falling edge, then wait n falling edges; cyc counts edges since release.
    task automatic applyStimulus(input logic rst_val, input int n);
        rst_n = rst_val;
        if (rst_val) cyc = 0;
        repeat (n) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Release reset and check the first pixel strobe and first counter step on the default instance.
    task automatic checkStartup(input string run);
        applyStimulus(1'b1, 3);
        checkOutput({run, "_pix_en_c3"}, 32'(d_pix_en), 32'd0);
        tick();
        checkOutput({run, "_pix_en_c4"}, 32'(d_pix_en), 32'd1);
        checkOutput({run, "_hc_c4"}, 32'(d_hc), 32'd0);
        tick();
        checkOutput({run, "_pix_en_c5"}, 32'(d_pix_en), 32'd0);
        checkOutput({run, "_hc_c5"}, 32'(d_hc), 32'd1);
        checkOutput({run, "_vc_c5"}, 32'(d_vc), 32'd0);
        checkOutput({run, "_hsync_c5"}, 32'(d_hsync), 32'd0);
        checkOutput({run, "_starts_c5"}, 32'({d_line_start, d_frame_start}), 32'd0);
    endtask

    // Hard time limit so a stuck design still produces a verdict.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r1, f1, r2, l1, l2, ls_n, fs_n;
        logic [9:0] l1_hc, l1_vc;
        logic l1_vs, prev_h;
        int sf1, sf2, sfs_n, dfs_n, vid_n, vs_low_n, hs_low_n, s_ls_n, vid_bad;
        logic [9:0] sf1_hc, sf1_vc, pre_hc, pre_vc, prev_hc, prev_vc, vr_hc, vr_vc, vf_hc;
        logic sf1_ls, prev_vid, vr_seen, vf_seen;

        // Reset values on both instances.
        applyStimulus(1'b0, 3);
        checkOutput("reset_d", 32'({d_pix_en, d_hsync, d_vsync, d_vidon, d_line_start, d_frame_start, d_hc, d_vc}), 32'd0);
        checkOutput("reset_s", 32'({s_pix_en, s_hsync, s_vsync, s_vidon, s_line_start, s_frame_start, s_hc, s_vc}), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        checkOutput("reset_frame_cnt", 32'(c_frame_cnt), 32'd0);
`endif

        checkStartup("run1");

        // Line timing on the default instance: hsync edges and line_start spacing.
        r1 = -1; f1 = -1; r2 = -1; l1 = -1; l2 = -1; ls_n = 0; fs_n = 0;
        l1_hc = '1; l1_vc = '1; l1_vs = 1'b1; prev_h = d_hsync;
        for (int i = 0; i < 7000; i++) begin
            tick();
            if (d_hsync && !prev_h) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0 && f1 >= 0) r2 = cyc;
            end
            if (!d_hsync && prev_h && f1 < 0) f1 = cyc;
            if (d_line_start) begin
                ls_n++;
                if (l1 < 0) begin
                    l1 = cyc; l1_hc = d_hc; l1_vc = d_vc; l1_vs = d_vsync;
                end else if (l2 < 0) begin
                    l2 = cyc;
                end
            end
            if (d_frame_start) fs_n++;
            prev_h = d_hsync;
        end
        checkOutput("hsync_first_rise", 32'(r1), 32'd385);
        checkOutput("hsync_high_clks", 32'(f1 - r1), 32'd2816);
        checkOutput("hsync_low_clks", 32'(r2 - f1), 32'd384);
        checkOutput("line_start_first", 32'(l1), 32'd3201);
        checkOutput("line_period", 32'(l2 - l1), 32'd3200);
        checkOutput("line_start_hc_vc", 32'({l1_hc, l1_vc}), 32'({10'd0, 10'd1}));
        checkOutput("vsync_line1", 32'(l1_vs), 32'd0);
        checkOutput("line_start_count", 32'(ls_n), 32'd2);
        checkOutput("no_frame_start_d", 32'(fs_n), 32'd0);
        checkOutput("vsync_line2", 32'(d_vsync), 32'd1);
        checkOutput("vidon_line2", 32'(d_vidon), 32'd0);

        // Mid-line reset: assert between clock edges and look before the next edge.
        for (int i = 0; i < 4000 && d_hc != 10'd400; i++) tick();
        checkOutput("pre_reset_hc", 32'(d_hc), 32'd400);
        checkOutput("pre_reset_vc_hsync", 32'({d_vc, d_hsync}), 32'({10'd2, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_d", 32'({d_pix_en, d_hsync, d_vsync, d_vidon, d_line_start, d_frame_start, d_hc, d_vc}), 32'd0);
        checkOutput("async_reset_s", 32'({s_pix_en, s_hsync, s_vsync, s_vidon, s_line_start, s_frame_start, s_hc, s_vc}), 32'd0);
        applyStimulus(1'b0, 2);

        checkStartup("run2");

        // Visible window and frame wrap on the shrunken instance.
        sf1 = -1; sf2 = -1; sfs_n = 0; dfs_n = 0; vid_n = 0; vs_low_n = 0; hs_low_n = 0; s_ls_n = 0; vid_bad = 0;
        sf1_hc = '1; sf1_vc = '1; sf1_ls = 1'b0; pre_hc = '0; pre_vc = '0;
        vr_seen = 1'b0; vf_seen = 1'b0; vr_hc = '1; vr_vc = '1; vf_hc = '1;
        prev_hc = s_hc; prev_vc = s_vc; prev_vid = s_vidon;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (s_frame_start) begin
                sfs_n++;
                if (sf1 < 0) begin
                    sf1 = cyc; sf1_hc = s_hc; sf1_vc = s_vc; sf1_ls = s_line_start;
                    pre_hc = prev_hc; pre_vc = prev_vc;
                end else if (sf2 < 0) begin
                    sf2 = cyc;
                end
            end
            if (sf1 >= 0 && sf2 < 0) begin
                if (s_vidon) vid_n++;
                if (!s_vsync) vs_low_n++;
                if (!s_hsync) hs_low_n++;
                if (s_line_start) s_ls_n++;
            end
            if (s_vidon && (s_vc < 10'd3 || s_vc >= 10'd10)) vid_bad++;
            if (s_vidon && !prev_vid && !vr_seen) begin
                vr_seen = 1'b1; vr_hc = s_hc; vr_vc = s_vc;
            end
            if (!s_vidon && prev_vid && !vf_seen) begin
                vf_seen = 1'b1; vf_hc = s_hc;
            end
            if (d_frame_start) dfs_n++;
`ifdef VGA_FRAME_CNT_EN
            if (cyc == 800) checkOutput("frame_cnt_after_3", 32'(c_frame_cnt), 32'd3);
`endif
            prev_hc = s_hc; prev_vc = s_vc; prev_vid = s_vidon;
        end
        checkOutput("vidon_rise_hc_vc", 32'({vr_hc, vr_vc}), 32'({10'd5, 10'd3}));
        checkOutput("vidon_fall_hc", 32'(vf_hc), 32'd17);
        checkOutput("vidon_outside_rows", 32'(vid_bad), 32'd0);
        checkOutput("vidon_clks_per_frame", 32'(vid_n), 32'd168);
        checkOutput("first_frame_start", 32'(sf1), 32'd481);
        checkOutput("frame_period", 32'(sf2 - sf1), 32'd480);
        checkOutput("pre_wrap_hc_vc", 32'({pre_hc, pre_vc}), 32'({10'd19, 10'd11}));
        checkOutput("wrap_hc_vc", 32'({sf1_hc, sf1_vc}), 32'd0);
        checkOutput("wrap_line_start", 32'(sf1_ls), 32'd1);
        checkOutput("frame_start_count", 32'(sfs_n), 32'd2);
        checkOutput("vsync_low_clks", 32'(vs_low_n), 32'd80);
        checkOutput("hsync_low_clks_frame", 32'(hs_low_n), 32'd72);
        checkOutput("lines_per_frame", 32'(s_ls_n), 32'd12);
        checkOutput("no_frame_start_after_reset", 32'(dfs_n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
